uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Synchronous FIFO that buffers bytes from the host/datapath ahead of the UART transmit controller.
- The write side accepts bytes from the producer (result formatter / debug path).
- The read side presents a non-empty flag, accepts a one-cycle pop strobe from the transmit controller, and holds the popped byte stable for the whole serial frame.

Parameters:
- DATA_W, 8, word width in bits; matches the transmit byte.
- ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W = 16 entries.
- AFULL_LVL, 12, level at or above which almost_full asserts.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe; one byte is pushed per cycle when high and not full.
- wr_data  input  DATA_W  byte to push.
- rd_en  input  1  pop strobe; connects to the controller's tx_read_buf.
- rd_data  output  DATA_W  registered popped byte; connects to tx_data.
- not_empty  output  1  at least one entry is stored; connects to tx_buf_not_empty.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AFULL_LVL.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset: one clock, asynchronous, active-high.
  - Asserting rst immediately clears wr_ptr, rd_ptr, count, overflow and underflow.
  - It also sets rd_data = 0, not_empty = 0, full = 0, almost_full = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored entries.
- Storage:
  - DEPTH x DATA_W register array.
  - wr_ptr and rd_ptr are ADDR_W bits wide and wrap naturally from DEPTH-1 to 0.
  - count is a separate ADDR_W+1 counter.
- Write:
  - If wr_en and count < DEPTH: mem[wr_ptr] <= wr_data, wr_ptr += 1.
  - If wr_en while full: data is dropped, pointers unchanged, overflow <= 1.
- Pop:
  - If rd_en and count > 0: rd_data <= mem[rd_ptr], rd_ptr += 1, all on the same edge.
  - rd_data then holds that value until the next accepted pop, so the data is stable across the full start/data/stop frame regardless of later writes.
  - If rd_en while empty: no change to rd_data or pointers, underflow <= 1.
- Simultaneous accepted write and pop:
  - Both happen and count is unchanged.
  - When count == 0, a concurrent write is not bypassed: the pop is rejected as an underflow and the write is stored.
  - When count == DEPTH, a concurrent pop frees a slot in the same cycle, so the write is accepted and no overflow is flagged.
- count update: +1 on accepted write only, −1 on accepted pop only, unchanged otherwise.
- Flags: not_empty, full and almost_full are registered and derived from the next count value, so they are valid in the cycle after the updating edge.
  - The transmit controller pops with a single-cycle pulse and re-samples not_empty only after its frame, so the flags are always current when it looks.
- Sticky flags: overflow and underflow clear only on reset.
- Latency:
  - Write to not_empty rising: 1 cycle.
  - Pop edge to new rd_data valid: 0 cycles after the edge, i.e. valid in the next cycle.

Test Plan:
1. Reset with FIFO partly filled → count=0, not_empty=0, rd_data=8'h00, overflow=0, underflow=0 immediately on rst, without waiting for a clock edge.
2. Write 8'hA5, 8'h3C, then one-cycle rd_en → after pop, rd_data=8'hA5 held for ≥200 cycles while a further 8'h77 is written; second pop gives rd_data=8'h3C; count sequence is 1,2,1,2,1.
3. Write 17 bytes 8'h00..8'h10 back-to-back → full=1 after the 16th write, almost_full=1 from the 12th, the 17th byte is dropped, overflow=1; 16 pops return 8'h00..8'h0F in order, then not_empty=0.
4. Pointer wrap: 40 interleaved single write/pop pairs with an incrementing pattern → every popped byte equals its written value, count stays ≤1, no overflow or underflow.
5. Full FIFO with wr_en and rd_en in the same cycle → write accepted, count stays 16, overflow=0, and the popped byte is the oldest entry.
6. Empty FIFO with rd_en and wr_en of 8'h5A in the same cycle → underflow=1, rd_data unchanged, count=1; the next pop returns 8'h5A.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Synchronous byte FIFO sitting in front of the UART transmit controller.
//   The producer pushes bytes with wr_en/wr_data. The transmit controller pops
//   with a single-cycle rd_en pulse. The popped byte is registered on rd_data
//   and held until the next accepted pop, so it stays stable for a whole
//   serial frame.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   wr_en        push strobe (ignored, and overflow flagged, while full)
//   wr_data      byte to push
//   rd_en        pop strobe (ignored, and underflow flagged, while empty)
//   rd_data      registered popped byte
//   not_empty    at least one entry stored
//   full         count == DEPTH
//   almost_full  count >= AFULL_LVL
//   count        occupancy, 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: pop attempted while empty
module uart_tx_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              not_empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              not_empty_q, not_empty_d;
  logic              full_q, full_d;
  logic              almost_full_q, almost_full_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic rd_ok;
  logic wr_ok;

  always_comb begin
    // A pop is only accepted from stored data; there is no write-through
    // bypass, so a pop on an empty FIFO is rejected even if a write arrives.
    rd_ok = rd_en && (count_q != '0);
    // A pop in the same cycle frees a slot, so a write into a full FIFO is
    // still accepted when paired with an accepted pop.
    wr_ok = wr_en && ((count_q != DEPTH_CNT) || rd_ok);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end

    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - 1'b1;
    end

    if (wr_en && !wr_ok) begin
      overflow_d = 1'b1;
    end
    if (rd_en && !rd_ok) begin
      underflow_d = 1'b1;
    end

    // Status flags come from the next occupancy so they are registered
    // and line up with count after the same edge.
    not_empty_d   = (count_d != '0);
    full_d        = (count_d == DEPTH_CNT);
    almost_full_d = (count_d >= AFULL_CNT);
  end

  // Storage has no reset; stale contents are unreachable after pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_data_q     <= '0;
      not_empty_q   <= 1'b0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rd_data_q     <= rd_data_d;
      not_empty_q   <= not_empty_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign not_empty   = not_empty_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed steps with a scoreboard queue of
// expected popped bytes and a small occupancy/flag reference.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       not_empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  uart_tx_fifo #(.DATA_W(8), .ADDR_W(4), .AFULL_LVL(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .not_empty  (not_empty),
    .full       (full),
    .almost_full(almost_full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [7:0] exp_q[$];
  int         m_count;
  logic [7:0] m_rd;
  bit         m_ovf;
  bit         m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_count = 0;
    m_rd    = 8'h00;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock: drive strobes, update the reference, compare every output.
  task automatic step(input bit w, input logic [7:0] d, input bit r);
    bit rok;
    bit wok;
    rok = r && (m_count > 0);
    wok = w && ((m_count < 16) || rok);
    if (w && !wok) m_ovf = 1'b1;
    if (r && !rok) m_udf = 1'b1;
    if (rok) m_rd = exp_q.pop_front();
    if (wok) exp_q.push_back(d);
    m_count = m_count + int'(wok) - int'(rok);

    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;

    chk("rd_data",     32'(rd_data),     32'(m_rd));
    chk("count",       32'(count),       32'(m_count));
    chk("not_empty",   32'(not_empty),   32'(m_count != 0));
    chk("full",        32'(full),        32'(m_count == 16));
    chk("almost_full", 32'(almost_full), 32'(m_count >= 12));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("underflow",   32'(underflow),   32'(m_udf));
    $display("step wr=%0d data=%02h rd=%0d -> rd_data=%02h count=%0d ovf=%0d udf=%0d",
             w, d, r, rd_data, count, overflow, underflow);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  bit hold_ok;

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_not_empty", 32'(not_empty), 32'd0);

    // 1. Asynchronous reset with data stored and rd_data non-zero
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_count",     32'(count),     32'd0);
    chk("async_rst_not_empty", 32'(not_empty), 32'd0);
    chk("async_rst_rd_data",   32'(rd_data),   32'h00);
    chk("async_rst_overflow",  32'(overflow),  32'd0);
    chk("async_rst_underflow", 32'(underflow), 32'd0);
    chk("async_rst_full",      32'(full),      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();

    // 2. Popped byte held across a long frame while another byte arrives
    step(1'b1, 8'hA5, 1'b0);
    chk("t2_count1", 32'(count), 32'd1);
    step(1'b1, 8'h3C, 1'b0);
    chk("t2_count2", 32'(count), 32'd2);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_pop1", 32'(rd_data), 32'hA5);
    chk("t2_count3", 32'(count), 32'd1);
    step(1'b1, 8'h77, 1'b0);
    chk("t2_count4", 32'(count), 32'd2);
    hold_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rd_data !== 8'hA5) hold_ok = 1'b0;
    end
    chk("t2_hold_a5", 32'(hold_ok), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_pop2", 32'(rd_data), 32'h3C);
    chk("t2_count5", 32'(count), 32'd1);

    // 3. Fill past full: 17 writes, the last is dropped
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 10) chk("t3_afull_before12", 32'(almost_full), 32'd0);
      if (i == 11) chk("t3_afull_at12", 32'(almost_full), 32'd1);
      if (i == 14) chk("t3_not_full15", 32'(full), 32'd0);
      if (i == 15) chk("t3_full16", 32'(full), 32'd1);
    end
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("t3_order", 32'(rd_data), 32'(i));
    end
    chk("t3_empty", 32'(not_empty), 32'd0);

    // 4. Pointer wrap with interleaved write/pop pairs
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("t4_value", 32'(rd_data), 32'(8'(8'h20 + i)));
      chk("t4_count_le1", 32'(count <= 5'd1), 32'd1);
    end
    chk("t4_overflow", 32'(overflow), 32'd0);
    chk("t4_underflow", 32'(underflow), 32'd0);

    // 5. Simultaneous write and pop on a full FIFO
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    chk("t5_popped_oldest", 32'(rd_data), 32'h80);
    chk("t5_count16", 32'(count), 32'd16);
    chk("t5_no_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    chk("t5_last_is_new", 32'(rd_data), 32'hEE);

    // 6. Simultaneous pop and write on an empty FIFO
    do_reset();
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    chk("t6_underflow", 32'(underflow), 32'd1);
    chk("t6_rd_unchanged", 32'(rd_data), 32'h11);
    chk("t6_count1", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_pop_5a", 32'(rd_data), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
